// File: rtl/fifo_pkg.sv
// Shared types and helpers for the synchronous FIFO controller.
// The status struct orders its fields {full, empty, afull, aempty}. The
// same bit order is used for the rise-pulse vector.
package fifo_pkg;

  localparam int FIFO_NUM_FLAGS = 4;

  typedef struct packed {
    logic full;
    logic empty;
    logic afull;
    logic aempty;
  } fifo_status_t;

  // The count must be able to hold DEPTH itself, so it needs one bit more than the address.
  function automatic int clog2_cnt(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/flag_edge_det.sv
// Rising-edge detector for a vector of level flags.
// The previous-value registers load rst_val on reset. If rst_val matches
// the flags just after reset, no pulse fires in the first cycle.
module flag_edge_det #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] flags,
  input  logic [N-1:0] rst_val,
  output logic [N-1:0] rise
);

  logic [N-1:0] flags_d1;

  // Remember each flag's value from the previous cycle.
  always_ff @(posedge clk) begin
    if (rst) flags_d1 <= rst_val;
    else     flags_d1 <= flags;
  end

  assign rise = flags & ~flags_d1;

endmodule

// File: rtl/sync_fifo_ctl.sv
// Synchronous show-ahead FIFO with guarded push/pop and programmable
// almost-full/almost-empty thresholds. It also provides sticky
// overflow/underflow flags and one-cycle rise pulses for every status flag.
// Optional: define FIFO_WATERMARK_EN to add the max_count high-watermark port.
module sync_fifo_ctl
  import fifo_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  parameter int CNT_W = clog2_cnt(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] datain,
  input  logic             pop,
  output logic [WIDTH-1:0] dataout,
  input  logic [CNT_W-1:0] afull_thresh,
  input  logic [CNT_W-1:0] aempty_thresh,
  input  logic             clear_err,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty,
  output logic             almost_full,
  output logic             almost_empty,
  output logic             full_rise,
  output logic             empty_rise,
  output logic             afull_rise,
  output logic             aempty_rise,
  output logic             overflow,
  output logic             underflow
`ifdef FIFO_WATERMARK_EN
  ,
  output logic [CNT_W-1:0] max_count
`endif
);

  localparam int ADDR_W = $clog2(DEPTH);

  logic [WIDTH-1:0]  mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [CNT_W-1:0]  count_next;
  logic              push_ok;
  logic              pop_ok;
  fifo_status_t      status;
  fifo_status_t      status_rst;
  fifo_status_t      status_rise;

  // Acceptance is judged against the registered flags, so a full FIFO never takes a push, even with a pop in the same cycle.
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;

  assign count_next = count + CNT_W'(push_ok) - CNT_W'(pop_ok);

  assign status.full   = (count == CNT_W'(DEPTH));
  assign status.empty  = (count == '0);
  assign status.afull  = (count >= afull_thresh);
  assign status.aempty = (count <= aempty_thresh);

  // Flag values at count == 0. almost_empty is always set there because the threshold is unsigned.
  assign status_rst.full   = 1'b0;
  assign status_rst.empty  = 1'b1;
  assign status_rst.afull  = (afull_thresh == '0);
  assign status_rst.aempty = 1'b1;

  assign full         = status.full;
  assign empty        = status.empty;
  assign almost_full  = status.afull;
  assign almost_empty = status.aempty;

  assign dataout = mem[rd_ptr];

  // Write the storage array; its contents are never reset.
  always_ff @(posedge clk) begin
    if (!rst && push_ok) mem[wr_ptr] <= datain;
  end

  // Pointers and occupancy. The pointers wrap naturally at DEPTH.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + ADDR_W'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + ADDR_W'(1);
      count <= count_next;
    end
  end

  // Sticky error flags. A new error wins over clear_err in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (push && full)   overflow <= 1'b1;
      else if (clear_err) overflow <= 1'b0;
      if (pop && empty)   underflow <= 1'b1;
      else if (clear_err) underflow <= 1'b0;
    end
  end

`ifdef FIFO_WATERMARK_EN
  // Track peak occupancy. clear_err restarts tracking from the current count.
  always_ff @(posedge clk) begin
    if (rst)                          max_count <= '0;
    else if (clear_err)               max_count <= count;
    else if (count_next > max_count)  max_count <= count_next;
  end
`endif

  flag_edge_det #(
    .N (FIFO_NUM_FLAGS)
  ) u_edge (
    .clk     (clk),
    .rst     (rst),
    .flags   (status),
    .rst_val (status_rst),
    .rise    (status_rise)
  );

  assign full_rise   = status_rise.full;
  assign empty_rise  = status_rise.empty;
  assign afull_rise  = status_rise.afull;
  assign aempty_rise = status_rise.aempty;

endmodule

// File: tb/tb_sync_fifo_ctl.sv
// Self-checking bench for sync_fifo_ctl. The reference model is a data queue plus sticky-flag bits.
module tb_sync_fifo_ctl;

  localparam int DEPTH = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       push = 1'b0;
  logic       pop = 1'b0;
  logic       clear_err = 1'b0;
  logic [7:0] datain = 8'h00;
  logic [7:0] dataout;
  logic [3:0] afull_thresh = 4'd6;
  logic [3:0] aempty_thresh = 4'd1;
  logic [3:0] count;
  logic       full, empty, almost_full, almost_empty;
  logic       full_rise, empty_rise, afull_rise, aempty_rise;
  logic       overflow, underflow;
`ifdef FIFO_WATERMARK_EN
  logic [3:0] max_count;
`endif

  sync_fifo_ctl #(.WIDTH(8), .DEPTH(DEPTH)) dut (
    .clk           (clk),
    .rst           (rst),
    .push          (push),
    .datain        (datain),
    .pop           (pop),
    .dataout       (dataout),
    .afull_thresh  (afull_thresh),
    .aempty_thresh (aempty_thresh),
    .clear_err     (clear_err),
    .count         (count),
    .full          (full),
    .empty         (empty),
    .almost_full   (almost_full),
    .almost_empty  (almost_empty),
    .full_rise     (full_rise),
    .empty_rise    (empty_rise),
    .afull_rise    (afull_rise),
    .aempty_rise   (aempty_rise),
    .overflow      (overflow),
    .underflow     (underflow)
`ifdef FIFO_WATERMARK_EN
    ,
    .max_count     (max_count)
`endif
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  // Reference model.
  logic [7:0] q[$];
  bit         m_ovf, m_udf;
  int         m_max;
  logic [3:0] m_old;
  int         ath = 6;
  int         eth = 1;

  logic [13:0] obs_stat;
  assign obs_stat = {count, full, empty, almost_full, almost_empty,
                     full_rise, empty_rise, afull_rise, aempty_rise, overflow, underflow};

  function automatic logic [3:0] mflags(input int n);
    return {n == DEPTH, n == 0, n >= ath, n <= eth};
  endfunction

  function automatic logic [13:0] exp_stat();
    logic [3:0] f;
    f = mflags(q.size());
    return {4'(q.size()), f, f & ~m_old, m_ovf, m_udf};
  endfunction

  // Apply one cycle of inputs and advance the model across the same clock edge.
  task automatic step(input logic p, input logic [7:0] d, input logic o,
                      input logic c, input logic r);
    int n;
    @(negedge clk);
    push = p; datain = d; pop = o; clear_err = c; rst = r;
    afull_thresh = 4'(ath); aempty_thresh = 4'(eth);
    n = q.size();
    if (r) begin
      q.delete();
      m_ovf = 0; m_udf = 0; m_max = 0;
      m_old = mflags(0);
    end else begin
      m_old = mflags(n);
      if (p && n == DEPTH) m_ovf = 1; else if (c) m_ovf = 0;
      if (o && n == 0)     m_udf = 1; else if (c) m_udf = 0;
      if (o && n > 0) void'(q.pop_front());
      if (p && n < DEPTH) q.push_back(d);
      if (c) m_max = n;
      else if (q.size() > m_max) m_max = q.size();
    end
    @(posedge clk);
    #1;
    push = 0; pop = 0; clear_err = 0; rst = 0;
  endtask

  task automatic test_reset();
    step(0, 8'h00, 0, 0, 1);
    step(0, 8'h00, 0, 0, 0);
    total++;
    if (obs_stat !== 14'b0000_0101_0000_00) begin
      $display("FAIL reset_state: got %b want %b", obs_stat, 14'b0000_0101_0000_00);
    end else passed++;
    total++;
    if (obs_stat !== exp_stat()) begin
      $display("FAIL reset_model: got %b want %b", obs_stat, exp_stat());
    end else passed++;
  endtask

  task automatic test_fill();
    int afr = 0, fr = 0;
    for (int i = 1; i <= 8; i++) begin
      step(1, 8'(i), 0, 0, 0);
      total++;
      if (obs_stat !== exp_stat()) begin
        $display("FAIL fill_stat[%0d]: got %b want %b", i, obs_stat, exp_stat());
      end else passed++;
      total++;
      if (dataout !== 8'h01) begin
        $display("FAIL fill_head[%0d]: got %h want 01", i, dataout);
      end else passed++;
      total++;
      if ({afull_rise, full_rise} !== {i == 6, i == 8}) begin
        $display("FAIL fill_rise[%0d]: got %b%b want %b%b", i, afull_rise, full_rise, i == 6, i == 8);
      end else passed++;
      afr += int'(afull_rise);
      fr  += int'(full_rise);
    end
    total++;
    if (afr != 1 || fr != 1) begin
      $display("FAIL fill_pulse_count: got afull=%0d full=%0d want 1 1", afr, fr);
    end else passed++;
  endtask

  task automatic test_drain(input int first);
    int er = 0;
    for (int i = first; i <= 8; i++) begin
      total++;
      if (dataout !== 8'(i) || dataout === 8'hAA) begin
        $display("FAIL drain_data[%0d]: got %h want %h", i, dataout, 8'(i));
      end else passed++;
      step(0, 8'h00, 1, 0, 0);
      total++;
      if (obs_stat !== exp_stat()) begin
        $display("FAIL drain_stat[%0d]: got %b want %b", i, obs_stat, exp_stat());
      end else passed++;
      er += int'(empty_rise);
    end
    total++;
    if (er != 1 || count !== 4'd0) begin
      $display("FAIL drain_end: got empty_rise=%0d count=%0d want 1 0", er, count);
    end else passed++;
  endtask

  task automatic test_full_push_pop();
    for (int i = 1; i <= 8; i++) step(1, 8'(i), 0, 0, 0);
    step(1, 8'hAA, 1, 0, 0);
    total++;
    if (count !== 4'd7 || overflow !== 1'b1 || dataout !== 8'h02) begin
      $display("FAIL full_push_pop: got count=%0d ovf=%b head=%h want 7 1 02", count, overflow, dataout);
    end else passed++;
    total++;
    if (obs_stat !== exp_stat()) begin
      $display("FAIL full_push_pop_stat: got %b want %b", obs_stat, exp_stat());
    end else passed++;
    test_drain(2);
  endtask

  task automatic test_underflow();
    step(0, 8'h00, 0, 1, 0);
    step(0, 8'h00, 1, 0, 0);
    total++;
    if (underflow !== 1'b1 || count !== 4'd0 || overflow !== 1'b0) begin
      $display("FAIL underflow_set: got udf=%b ovf=%b count=%0d want 1 0 0", underflow, overflow, count);
    end else passed++;
    step(0, 8'h00, 1, 1, 0);
    total++;
    if (underflow !== 1'b1) begin
      $display("FAIL underflow_set_wins: got %b want 1", underflow);
    end else passed++;
    step(0, 8'h00, 0, 1, 0);
    total++;
    if (underflow !== 1'b0 || count !== 4'd0) begin
      $display("FAIL underflow_clear: got udf=%b count=%0d want 0 0", underflow, count);
    end else passed++;
    total++;
    if (obs_stat !== exp_stat()) begin
      $display("FAIL underflow_stat: got %b want %b", obs_stat, exp_stat());
    end else passed++;
  endtask

  // Random push/pop bursts with rst asserted in the middle.
  task automatic test_wrap(input int cycles, input int rst_at);
    int  burst = 0;
    bit  mode = 0;
    bit  p, o;
    for (int c = 0; c < cycles; c++) begin
      if (burst == 0) begin
        burst = $urandom_range(5, 1);
        mode  = 1'($urandom_range(1));
      end
      burst--;
      p = mode ? ($urandom_range(3) != 0) : ($urandom_range(3) == 0);
      o = mode ? ($urandom_range(3) == 0) : ($urandom_range(3) != 0);
      step(p, 8'($urandom), o, ($urandom_range(15) == 0), c == rst_at);
      total++;
      if (obs_stat !== exp_stat()) begin
        $display("FAIL wrap_stat[%0d]: got %b want %b", c, obs_stat, exp_stat());
      end else passed++;
      if (q.size() > 0) begin
        total++;
        if (dataout !== q[0]) begin
          $display("FAIL wrap_data[%0d]: got %h want %h", c, dataout, q[0]);
        end else passed++;
      end
      if (c == rst_at) begin
        total++;
        if (count !== 4'd0 || empty !== 1'b1) begin
          $display("FAIL wrap_reset: got count=%0d empty=%b want 0 1", count, empty);
        end else passed++;
      end
`ifdef FIFO_WATERMARK_EN
      total++;
      if (max_count !== 4'(m_max)) begin
        $display("FAIL watermark[%0d]: got %0d want %0d", c, max_count, m_max);
      end else passed++;
`endif
    end
  endtask

  // Random operation with thresholds reprogrammed every few cycles.
  task automatic test_thresholds();
    for (int c = 0; c < 60; c++) begin
      if (c % 8 == 0) begin
        ath = $urandom_range(8);
        eth = $urandom_range(8);
      end
      step(($urandom_range(2) != 0), 8'($urandom), ($urandom_range(2) == 0), 0, 0);
      total++;
      if (obs_stat !== exp_stat()) begin
        $display("FAIL thresh_stat[%0d] ath=%0d eth=%0d: got %b want %b", c, ath, eth, obs_stat, exp_stat());
      end else passed++;
    end
    ath = 6;
    eth = 1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    m_ovf = 0; m_udf = 0; m_max = 0; m_old = 4'b0101;
    test_reset();
    test_fill();
    test_drain(1);
    test_full_push_pop();
    test_underflow();
    test_wrap(40, 20);
    test_thresholds();
    test_wrap(60, 45);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
